// File: rtl/equifiller_feeder_if.sv
// ============================================================================
//  Module      : equifiller_feeder_if
//  Description : Request / slot bundle between a request source and the
//                equifiller_feeder request-buffering stage.
//                Request side : req_valid_i, req_ready_o, req_height_i,
//                               req_width_i
//                Slot side    : height_o, width_o, slot_valid_o, seq_o
//                Status       : drop_o, level_o (AW+1 bits)
//                Optional     : accept_cnt_o, drop_cnt_o, idle_cnt_o when
//                               EQUIFILLER_FEEDER_STATS_EN is defined
//                Modports     : master (request source / observer side),
//                               slave  (the feeder itself)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface equifiller_feeder_if #(
   parameter int AW = 3
);
   logic          req_valid_i;
   logic          req_ready_o;
   logic [4:0]    req_height_i;
   logic [4:0]    req_width_i;
   logic [4:0]    height_o;
   logic [4:0]    width_o;
   logic          slot_valid_o;
   logic [7:0]    seq_o;
   logic          drop_o;
   logic [AW:0]   level_o;
`ifdef EQUIFILLER_FEEDER_STATS_EN
   logic [15:0]   accept_cnt_o;
   logic [15:0]   drop_cnt_o;
   logic [15:0]   idle_cnt_o;
`endif

   modport master (
`ifdef EQUIFILLER_FEEDER_STATS_EN
      input  accept_cnt_o, drop_cnt_o, idle_cnt_o,
`endif
      output req_valid_i, req_height_i, req_width_i,
      input  req_ready_o, height_o, width_o, slot_valid_o, seq_o,
             drop_o, level_o
   );

   modport slave (
`ifdef EQUIFILLER_FEEDER_STATS_EN
      output accept_cnt_o, drop_cnt_o, idle_cnt_o,
`endif
      input  req_valid_i, req_height_i, req_width_i,
      output req_ready_o, height_o, width_o, slot_valid_o, seq_o,
             drop_o, level_o
   );
endinterface

`default_nettype wire

// File: rtl/equifiller_feeder.sv
// ============================================================================
//  Module      : equifiller_feeder
//  Description : Request-buffering stage in front of the strip allocator.
//                Accepts program-size requests on a valid/ready handshake,
//                drops sizes the allocator cannot place, queues the rest in
//                a DEPTH-entry FIFO and presents one request per 4-clock
//                allocator slot, held stable around the allocator's sampling
//                edge. An empty queue yields a 0/0 idle slot.
//  Ports       : clk_i        - clock, rising edge
//                rst_i        - asynchronous active-high reset
//                feed (slave) - request handshake, slot outputs, drop pulse,
//                               occupancy and optional statistics
//  Parameters  : DEPTH - FIFO entries (power of two, 2..64)
//                AW    - log2(DEPTH)
//                MAX_H - largest legal program height
//  Config      : EQUIFILLER_FEEDER_STATS_EN adds saturating 16-bit counters
//                accept_cnt_o, drop_cnt_o and idle_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equifiller_feeder #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int MAX_H = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   equifiller_feeder_if.slave  feed
);

   // Phase values. The counter mirrors the allocator's slot counter: the
   // allocator samples when phase is 0, so loading at phase 2 gives two
   // cycles of setup and two cycles of hold around every sample.
   localparam logic [1:0] PHASE_RESET = 2'd3;
   localparam logic [1:0] PHASE_LOAD  = 2'd2;

   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [5:0]  MAX_H_VAL = 6'(MAX_H);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [9:0]    mem [DEPTH];        // {height, width}
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [1:0]    phase;
   logic [7:0]    tag;

   logic [4:0]    slot_height;
   logic [4:0]    slot_width;
   logic          slot_valid;
   logic [7:0]    slot_seq;
   logic          drop_pulse;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic          fifo_empty;
   logic          fifo_full;
   logic          load_edge;
   logic          height_ok;
   logic          width_ok;
   logic          legal;
   logic          xfer;
   logic          push;
   logic          pop;
   logic [9:0]    head;

   // The extra pointer MSB separates full (MSBs differ, indices equal) from
   // empty (pointers identical) without a separate occupancy register.
   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                       (wptr[AW-1:0] == rptr[AW-1:0]);

   assign load_edge  = (phase == PHASE_LOAD);

   assign height_ok  = (feed.req_height_i != 5'd0) &&
                       ({1'b0, feed.req_height_i} <= MAX_H_VAL);
   assign width_ok   = (feed.req_width_i != 5'd0);
   assign legal      = height_ok && width_ok;

   // Ready depends on occupancy only, never on valid.
   assign feed.req_ready_o = ~fifo_full;

   assign xfer  = feed.req_valid_i && ~fifo_full;
   assign push  = xfer && legal;
   assign pop   = load_edge && ~fifo_empty;

   // Head is read from the pre-edge read pointer, so an entry written on
   // the same edge can never fall through to the slot outputs.
   assign head  = mem[rptr[AW-1:0]];

   // ------------------------------------------------------------------------
   // FIFO array. Contents are not reset: the pointers alone decide which
   // entries are meaningful, so stale data is never observable.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= {feed.req_height_i, feed.req_width_i};
      end
   end

   // ------------------------------------------------------------------------
   // Pointers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   assign feed.level_o = wptr - rptr;

   // ------------------------------------------------------------------------
   // Slot phase counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase <= PHASE_RESET;
      end else begin
         phase <= phase + 2'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Slot outputs: change only on load edges. An idle slot clears
   // height/width/valid but leaves the sequence tag of the last real slot.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_height <= 5'd0;
         slot_width  <= 5'd0;
         slot_valid  <= 1'b0;
         slot_seq    <= 8'd0;
         tag         <= 8'd0;
      end else if (load_edge) begin
         if (!fifo_empty) begin
            slot_height <= head[9:5];
            slot_width  <= head[4:0];
            slot_valid  <= 1'b1;
            slot_seq    <= tag;
            tag         <= tag + 8'd1;
         end else begin
            slot_height <= 5'd0;
            slot_width  <= 5'd0;
            slot_valid  <= 1'b0;
         end
      end
   end

   assign feed.height_o     = slot_height;
   assign feed.width_o      = slot_width;
   assign feed.slot_valid_o = slot_valid;
   assign feed.seq_o        = slot_seq;

   // ------------------------------------------------------------------------
   // Drop pulse: registered, one cycle per consumed illegal request; back to
   // back illegal transfers therefore hold it high continuously.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= xfer && ~legal;
      end
   end

   assign feed.drop_o = drop_pulse;

`ifdef EQUIFILLER_FEEDER_STATS_EN
   // ------------------------------------------------------------------------
   // Saturating statistics counters
   // ------------------------------------------------------------------------
   logic [15:0] accept_cnt;
   logic [15:0] drop_cnt;
   logic [15:0] idle_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         accept_cnt <= 16'd0;
         drop_cnt   <= 16'd0;
         idle_cnt   <= 16'd0;
      end else begin
         if (push && (accept_cnt != CNT_MAX)) begin
            accept_cnt <= accept_cnt + 16'd1;
         end
         if (xfer && ~legal && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (load_edge && fifo_empty && (idle_cnt != CNT_MAX)) begin
            idle_cnt <= idle_cnt + 16'd1;
         end
      end
   end

   assign feed.accept_cnt_o = accept_cnt;
   assign feed.drop_cnt_o   = drop_cnt;
   assign feed.idle_cnt_o   = idle_cnt;
`else
   // Keeps the constant referenced in builds without the counters.
   logic unused_cnt_max;
   assign unused_cnt_max = ^CNT_MAX;
`endif

endmodule

`default_nettype wire

// File: doc/equifiller_feeder.md
# equifiller_feeder

Request-buffering stage directly upstream of the strip allocator. It accepts program-size requests over a valid/ready handshake, screens out sizes the allocator cannot place, and queues the rest in a FIFO. It presents exactly one request per allocator slot (one every 4 clocks) on `height_o`/`width_o`, held stable across the allocator's sampling edge. A 0/0 idle pattern is driven when the queue is empty, and the allocator ignores it.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, range 2..64.
- `AW`, default 3: log2(`DEPTH`).
- `MAX_H`, default 16: largest legal program height.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: feeder can take a request.
- `req_height_i` in 5: requested program height.
- `req_width_i` in 5: requested program width.
- `height_o` out 5: height for the allocator's `height_i`.
- `width_o` out 5: width for the allocator's `width_i`.
- `slot_valid_o` out 1: the current slot carries a real request.
- `seq_o` out 8: sequence tag of the current slot's request, for downstream matching of allocator results.
- `drop_o` out 1: one-cycle pulse when an illegal request is consumed.
- `level_o` out AW+1: FIFO occupancy, 0..DEPTH.

## Operation
- **Phase counter**
  - 2-bit `phase`; reset value 3; increments every clock and wraps 3->0.
  - This mirrors the allocator's slot counter, so the allocator samples on edges where `phase`==0.
- **Slot load edge**: edges where `phase`==2.
  - FIFO not empty: pop the head into `height_o`/`width_o`, set `slot_valid_o`=1, and set `seq_o` to the next tag. The tag counter starts at 0 and increments by 1 mod 256 per real pop.
  - FIFO empty: drive `height_o`=0, `width_o`=0, `slot_valid_o`=0; `seq_o` holds its previous value.
  - On all other edges, the slot outputs hold.
- **Handshake**
  - `req_ready_o` = (`level_o` != DEPTH). It is combinational from occupancy only and never depends on `req_valid_i`.
  - A transfer occurs on an edge with `req_valid_i` && `req_ready_o`.
- **Legality**
  - A request is legal iff `req_height_i` in 1..MAX_H and `req_width_i` != 0.
  - Legal transfer: write to the FIFO tail.
  - Illegal transfer: the request is consumed but not written, and `drop_o`=1 for the following cycle.
- **FIFO**
  - Write and read pointers are AW+1 bits, giving wrap-around with an explicit full/empty distinction.
  - `level_o` = wptr - rptr.
- **Simultaneous push and pop** on a load edge: both happen and `level_o` is unchanged.
  - The pop takes the pre-edge head. There is no fall-through: an entry written on edge N is poppable no earlier than the next load edge after N.
  - A push while full cannot occur, because ready is low.
- **Reset, any time**
  - Pointers, level, tag, `phase`=3, all outputs 0, `req_ready_o`=1.
  - Queued requests are discarded.

## Timing
- **Reset values**: `req_ready_o`=1; `height_o`=0, `width_o`=0, `slot_valid_o`=0, `seq_o`=0, `drop_o`=0, `level_o`=0; stats counters 0.
- **After reset release**:
  - Edge 1: `phase` 3->0.
  - Edge 2: allocator samples (sees 0/0).
  - Edge 4: first load edge.
  - Edge 6: allocator samples the first loaded slot.
- **Hold time**: slot outputs change only at `phase`==2 edges, so they are stable for the 2 cycles before and the 2 cycles after each allocator sample.
- **Latency**: a request pushed into an empty FIFO reaches the outputs at the next load edge (1-4 cycles). The allocator captures it 2 cycles after that.
- **Throughput**
  - Output side: one request per 4 clocks.
  - Input side: one per clock until full.
- `drop_o` is registered and lasts one cycle per illegal transfer. Back-to-back illegal transfers give a continuous high.

## Configuration
- `EQUIFILLER_FEEDER_STATS_EN` defined:
  - Adds 16-bit saturating outputs `accept_cnt_o` (legal transfers), `drop_cnt_o` (illegal transfers) and `idle_cnt_o` (load edges with an empty FIFO).
  - All three reset to 0 and stop at 65535.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Basic slotting**: reset, then push legal (12,30) at cycle 1 -> load at edge 4 gives `height_o`=12, `width_o`=30, `slot_valid_o`=1, `seq_o`=0; outputs stable through edge 7; edge 8 gives 0/0 with `slot_valid_o`=0.
- **Fill to full**: push 9 legal requests back-to-back with DEPTH=8 and no load edge yet -> `req_ready_o`=0 once `level_o`=8; the 9th is held off; one load edge later `level_o`=7 and ready=1.
- **Illegal inputs**: push (0,5), (17,5), (4,0) -> each is consumed, `drop_o` pulses once per request, `level_o` stays 0, slots stay 0/0.
- **Wrap and ordering**: stream 20 legal requests of (k mod 16)+1 x 10 -> outputs appear in order with `seq_o` 0..19; pointers wrap with no loss or duplication.
- **Same-edge push/pop**: `level_o`=1, push on a load edge -> head popped, `level_o` stays 1, new entry appears at the next load edge.
- **Mid-slot reset**: assert `rst_i` between edges with `level_o`=5 -> all outputs go to reset values immediately, `phase`=3, and the first post-reset load edge shows 0/0.
